// File: rtl/bist_sequencer_pkg.sv
// Shared types, tap constants and next-state helpers for the BIST sequencer
// and its MISR sub-module.
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_APPLY,
    ST_COMPARE,
    ST_DONE
  } bist_state_t;

  // Fibonacci LFSR taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3 feed bit 0)
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;
  // MISR feedback mask for x^4+x+1 (feedback enters bits 0 and 1)
  localparam logic [3:0] MISR_POLY = 4'b0011;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [3:0] misr_next(input logic [3:0] s, input logic [3:0] r);
    return {s[2:0], 1'b0} ^ (s[3] ? MISR_POLY : 4'h0) ^ r;
  endfunction

endpackage

// File: rtl/bist_sequencer_if.sv
// Functional/CUT/status bundle between the BIST sequencer and its system.
interface bist_if;
  logic       bist_start;
  logic       bist_abort;
  logic [3:0] func_a;
  logic [3:0] func_b;
  logic [3:0] cut_result;
  logic [3:0] cut_a;
  logic [3:0] cut_b;
  logic       bist_active;
  logic       bist_done;
  logic       fault_detected;
  logic [3:0] misr_signature;
  logic [7:0] pattern_cnt;

  // System side: requests sessions, supplies operands and the CUT result
  modport master (
    output bist_start, bist_abort, func_a, func_b, cut_result,
    input  cut_a, cut_b, bist_active, bist_done, fault_detected,
           misr_signature, pattern_cnt
  );

  // Sequencer side
  modport slave (
    input  bist_start, bist_abort, func_a, func_b, cut_result,
    output cut_a, cut_b, bist_active, bist_done, fault_detected,
           misr_signature, pattern_cnt
  );
endinterface

// File: rtl/bist_sequencer_misr.sv
// 4-bit multiple-input signature register (x^4+x+1) with load and enable.
module bist_misr
  import bist_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic       i_en,
  input  logic [3:0] i_seed,
  input  logic [3:0] i_data,
  output logic [3:0] o_sig
);

  logic [3:0] r_sig;

  // Signature register: load wins over compaction
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sig <= 4'h0;
    end else if (i_load) begin
      r_sig <= i_seed;
    end else if (i_en) begin
      r_sig <= misr_next(r_sig, i_data);
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/bist_sequencer.sv
// BIST session sequencer: LFSR operand generator, pattern counter, MISR
// compaction and golden-signature compare, with functional pass-through.
module bist_sequencer
  import bist_pkg::*;
#(
  parameter int unsigned PATTERN_COUNT = 255,
  parameter logic [7:0]  LFSR_SEED     = 8'h01,
  parameter logic [3:0]  MISR_SEED     = 4'h0,
  parameter logic [3:0]  GOLDEN_SIG    = 4'b0101
) (
  input  logic  clk,
  input  logic  rst,
  bist_if.slave if_bist
);

  localparam logic [7:0] LP_LAST_CNT = 8'(PATTERN_COUNT - 1);

  bist_state_t r_state, w_state_nxt;
  logic [7:0]  r_lfsr;
  logic [7:0]  r_cnt;
  logic        r_fault;
  logic [3:0]  w_sig;
  logic        w_init;
  logic        w_step;
  logic        w_fault_clr;
  logic        w_fault_upd;
  logic        w_active;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and control strobes; abort beats every other transition
  // while a session is in flight, start is only heard in IDLE/DONE
  always_comb begin
    w_state_nxt = r_state;
    w_init      = 1'b0;
    w_step      = 1'b0;
    w_fault_clr = 1'b0;
    w_fault_upd = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (if_bist.bist_start) w_state_nxt = ST_INIT;
      end
      ST_INIT: begin
        w_fault_clr = 1'b1;
        if (if_bist.bist_abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_init      = 1'b1;
          w_state_nxt = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (if_bist.bist_abort) begin
          w_fault_clr = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_cnt == LP_LAST_CNT) w_state_nxt = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (if_bist.bist_abort) begin
          w_fault_clr = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_fault_upd = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (if_bist.bist_start) w_state_nxt = ST_INIT;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Pattern generator, pattern counter and registered verdict
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr  <= LFSR_SEED;
      r_cnt   <= 8'h00;
      r_fault <= 1'b0;
    end else begin
      if (w_init) begin
        r_lfsr <= LFSR_SEED;
        r_cnt  <= 8'h00;
      end else if (w_step) begin
        r_lfsr <= lfsr_next(r_lfsr);
        r_cnt  <= r_cnt + 8'h01;
      end
      if (w_fault_clr)      r_fault <= 1'b0;
      else if (w_fault_upd) r_fault <= (w_sig != GOLDEN_SIG);
    end
  end

  // The CUT is combinational, so the result seen in an APPLY cycle belongs
  // to the operands driven in that same cycle
  bist_misr u_misr (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_load (w_init),
    .i_en   (w_step),
    .i_seed (MISR_SEED),
    .i_data (if_bist.cut_result),
    .o_sig  (w_sig)
  );

  assign w_active = (r_state == ST_INIT) || (r_state == ST_APPLY) ||
                    (r_state == ST_COMPARE);

  assign if_bist.cut_a          = w_active ? r_lfsr[7:4] : if_bist.func_a;
  assign if_bist.cut_b          = w_active ? r_lfsr[3:0] : if_bist.func_b;
  assign if_bist.bist_active    = w_active;
  assign if_bist.bist_done      = (r_state == ST_DONE);
  assign if_bist.fault_detected = r_fault;
  assign if_bist.misr_signature = w_sig;
  assign if_bist.pattern_cnt    = r_cnt;

endmodule

// File: tb/tb_bist_sequencer.sv
// Directed bench for bist_sequencer: three instances (N=4 adder CUT, N=1
// constant CUT, N=255 xor/rotate CUT) checked against a reference model.
module tb_bist_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   guard;
  logic [7:0] q_ops[$];
  logic [3:0] q_sig[$];
  logic [7:0] e_ops;
  logic [3:0] e_sig;
  logic [3:0] r1_val;

  always #5 clk = ~clk;

  bist_if if4 ();
  bist_if if1 ();
  bist_if if255 ();

  // Reference pattern generator and compactor
  function automatic logic [7:0] m_lfsr(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [3:0] m_misr(input logic [3:0] s, input logic [3:0] r);
    logic [3:0] n;
    n[0] = s[3] ^ r[0];
    n[1] = s[0] ^ s[3] ^ r[1];
    n[2] = s[1] ^ r[2];
    n[3] = s[2] ^ r[3];
    return n;
  endfunction

  function automatic logic [3:0] cut_xr(input logic [3:0] a, input logic [3:0] b);
    return a ^ {b[2:0], b[3]};
  endfunction

  assign if4.cut_result   = if4.cut_a + if4.cut_b;
  assign if1.cut_result   = r1_val;
  assign if255.cut_result = cut_xr(if255.cut_a, if255.cut_b);

  bist_sequencer #(.PATTERN_COUNT(4)) u_dut4 (
    .clk(clk), .rst(rst), .if_bist(if4.slave));
  bist_sequencer #(.PATTERN_COUNT(1), .GOLDEN_SIG(4'h5)) u_dut1 (
    .clk(clk), .rst(rst), .if_bist(if1.slave));
  bist_sequencer u_dut255 (
    .clk(clk), .rst(rst), .if_bist(if255.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push expected operands and final signature of one session.
  // kind 0: adder CUT, 1: xor/rotate CUT, 2: constant CUT value cval
  task automatic push_session(input int n, input int kind, input logic [3:0] cval,
                              input bit push_ops);
    logic [7:0] l;
    logic [3:0] m, r;
    l = 8'h01;
    m = 4'h0;
    for (int i = 0; i < n; i++) begin
      if (push_ops) q_ops.push_back(l);
      case (kind)
        0:       r = l[7:4] + l[3:0];
        1:       r = cut_xr(l[7:4], l[3:0]);
        default: r = cval;
      endcase
      m = m_misr(m, r);
      l = m_lfsr(l);
    end
    q_sig.push_back(m);
  endtask

  task automatic pop_ops(output logic [7:0] v);
    if (q_ops.size() == 0) begin
      total++;
      bad++;
      $error("FAIL ops_queue_empty: observed=0 expected=1");
      v = 8'h00;
    end else begin
      v = q_ops.pop_front();
    end
  endtask

  task automatic pop_sig(output logic [3:0] v);
    if (q_sig.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sig_queue_empty: observed=0 expected=1");
      v = 4'h0;
    end else begin
      v = q_sig.pop_front();
    end
  endtask

  initial begin
    rst = 1'b1;
    r1_val = 4'h5;
    if4.bist_start = 1'b0;   if4.bist_abort = 1'b0;
    if1.bist_start = 1'b0;   if1.bist_abort = 1'b0;
    if255.bist_start = 1'b0; if255.bist_abort = 1'b0;
    if4.func_a = 4'h3;   if4.func_b = 4'hA;
    if1.func_a = 4'h3;   if1.func_b = 4'hA;
    if255.func_a = 4'h3; if255.func_b = 4'hA;

    // Reset behaviour
    tick();
    tick();
    check("rst_active", 8'(if255.bist_active), 8'h0);
    check("rst_done",   8'(if255.bist_done), 8'h0);
    check("rst_fault",  8'(if255.fault_detected), 8'h0);
    check("rst_sig",    8'(if255.misr_signature), 8'h0);
    check("rst_cnt",    if255.pattern_cnt, 8'h0);
    check("rst_cut_a",  8'(if255.cut_a), 8'h3);
    check("rst_cut_b",  8'(if255.cut_b), 8'hA);
    check("rst_done4",  8'(if4.bist_done), 8'h0);
    rst = 1'b0;
    tick();

    // LFSR sequence, N=4, adder CUT
    push_session(4, 0, 4'h0, 1'b1);
    if4.bist_start = 1'b1;
    tick();
    if4.bist_start = 1'b0;
    check("n4_init_active", 8'(if4.bist_active), 8'h1);
    check("n4_init_cnt", if4.pattern_cnt, 8'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("n4_cnt", if4.pattern_cnt, 8'(i));
      pop_ops(e_ops);
      check("n4_cut_a", 8'(if4.cut_a), 8'(e_ops[7:4]));
      check("n4_cut_b", 8'(if4.cut_b), 8'(e_ops[3:0]));
      tick();
    end
    check("n4_cmp_cnt", if4.pattern_cnt, 8'h4);
    check("n4_cmp_done", 8'(if4.bist_done), 8'h0);
    tick();
    pop_sig(e_sig);
    check("n4_done", 8'(if4.bist_done), 8'h1);
    check("n4_active", 8'(if4.bist_active), 8'h0);
    check("n4_sig", 8'(if4.misr_signature), 8'(e_sig));
    check("n4_fault", 8'(if4.fault_detected), 8'(e_sig != 4'h5));
    check("n4_pass_a", 8'(if4.cut_a), 8'h3);

    // Pass case, N=1, CUT tied to 5
    r1_val = 4'h5;
    push_session(1, 2, 4'h5, 1'b0);
    if1.bist_start = 1'b1;
    tick();
    if1.bist_start = 1'b0;
    tick();
    tick();
    check("pass_early_done", 8'(if1.bist_done), 8'h0);
    tick();
    pop_sig(e_sig);
    check("pass_done", 8'(if1.bist_done), 8'h1);
    check("pass_sig", 8'(if1.misr_signature), 8'(e_sig));
    check("pass_fault", 8'(if1.fault_detected), 8'h0);

    // Fail case, restart from DONE with CUT tied to 4
    r1_val = 4'h4;
    push_session(1, 2, 4'h4, 1'b0);
    if1.bist_start = 1'b1;
    tick();
    if1.bist_start = 1'b0;
    check("fail_restart_active", 8'(if1.bist_active), 8'h1);
    check("fail_restart_fault", 8'(if1.fault_detected), 8'h0);
    tick();
    tick();
    tick();
    pop_sig(e_sig);
    check("fail_done", 8'(if1.bist_done), 8'h1);
    check("fail_sig", 8'(if1.misr_signature), 8'(e_sig));
    check("fail_fault", 8'(if1.fault_detected), 8'h1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("fail_hold_done", 8'(if1.bist_done), 8'h1);
      check("fail_hold_fault", 8'(if1.fault_detected), 8'h1);
      check("fail_hold_sig", 8'(if1.misr_signature), 8'h4);
    end

    // Start and abort together in DONE: start wins; abort then hits INIT
    if1.bist_start = 1'b1;
    if1.bist_abort = 1'b1;
    tick();
    if1.bist_start = 1'b0;
    check("both_start_wins", 8'(if1.bist_active), 8'h1);
    tick();
    if1.bist_abort = 1'b0;
    check("init_abort_active", 8'(if1.bist_active), 8'h0);
    check("init_abort_done", 8'(if1.bist_done), 8'h0);
    check("init_abort_fault", 8'(if1.fault_detected), 8'h0);

    // Abort at pattern_cnt=100, N=255
    if255.bist_start = 1'b1;
    tick();
    if255.bist_start = 1'b0;
    guard = 0;
    while (if255.pattern_cnt != 8'd100 && guard < 300) begin
      tick();
      guard++;
    end
    check("abort_reach_cnt", if255.pattern_cnt, 8'd100);
    if255.bist_abort = 1'b1;
    if255.func_a = 4'h6;
    if255.func_b = 4'h9;
    tick();
    if255.bist_abort = 1'b0;
    check("abort_active", 8'(if255.bist_active), 8'h0);
    check("abort_done", 8'(if255.bist_done), 8'h0);
    check("abort_fault", 8'(if255.fault_detected), 8'h0);
    check("abort_cut_a", 8'(if255.cut_a), 8'h6);
    check("abort_cut_b", 8'(if255.cut_b), 8'h9);
    tick();
    check("abort_stays_idle", 8'(if255.bist_active), 8'h0);

    // Reset mid-APPLY at pattern_cnt=50
    if255.bist_start = 1'b1;
    tick();
    if255.bist_start = 1'b0;
    guard = 0;
    while (if255.pattern_cnt != 8'd50 && guard < 300) begin
      tick();
      guard++;
    end
    check("rst_reach_cnt", if255.pattern_cnt, 8'd50);
    rst = 1'b1;
    tick();
    check("mid_rst_active", 8'(if255.bist_active), 8'h0);
    check("mid_rst_done", 8'(if255.bist_done), 8'h0);
    check("mid_rst_fault", 8'(if255.fault_detected), 8'h0);
    check("mid_rst_sig", 8'(if255.misr_signature), 8'h0);
    check("mid_rst_cnt", if255.pattern_cnt, 8'h0);
    check("mid_rst_cut_a", 8'(if255.cut_a), 8'h6);
    rst = 1'b0;
    tick();

    // Full uninterrupted session after reset
    push_session(255, 1, 4'h0, 1'b1);
    if255.bist_start = 1'b1;
    tick();
    if255.bist_start = 1'b0;
    tick();
    for (int i = 0; i < 255; i++) begin
      pop_ops(e_ops);
      check("full_cut_a", 8'(if255.cut_a), 8'(e_ops[7:4]));
      check("full_cut_b", 8'(if255.cut_b), 8'(e_ops[3:0]));
      tick();
    end
    check("full_cnt", if255.pattern_cnt, 8'd255);
    guard = 0;
    while (!if255.bist_done && guard < 5) begin
      tick();
      guard++;
    end
    pop_sig(e_sig);
    check("full_done", 8'(if255.bist_done), 8'h1);
    check("full_sig", 8'(if255.misr_signature), 8'(e_sig));
    check("full_fault", 8'(if255.fault_detected), 8'(e_sig != 4'b0101));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
